field_lock_engine: RTL and testbench

Sequential successor to the combinational field merger: overlays a rotated BLK×BLK piece onto the playfield one cell per cycle. Reports collision and out-of-bounds. In lock mode, commits the piece and optionally compacts full rows. Sits between the game-control FSM, which issues `start`, and the field register and display path, which consume `field_out`.

---
 rtl/field_pkg.sv | 28 ++
 rtl/field_row_compact.sv | 71 +++++++
 rtl/field_lock_engine.sv | 215 +++++++++++++++++++++
 tb/tb_field_lock_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/field_pkg.sv
// Shared state encoding, default geometry and rotation index helper for the field lock engine.
package field_pkg;

    localparam int FIELD_W_DEF = 20;
    localparam int FIELD_H_DEF = 20;
    localparam int BLK_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CLEAR,
        DONE
    } state_e;

    // Piece matrix bit that lands on output cell (i, j) after k clockwise quarter turns.
    function automatic int rot_src_idx(input logic [1:0] rotate, input int i, input int j, input int blk);
        int r;
        int c;
        case (rotate)
            2'd0:    begin r = i;           c = j;           end
            2'd1:    begin r = blk - 1 - j; c = i;           end
            2'd2:    begin r = blk - 1 - i; c = blk - 1 - j; end
            default: begin r = j;           c = blk - 1 - i; end
        endcase
        return r * blk + c;
    endfunction

endpackage

// File: rtl/field_row_compact.sv
// Row compactor: walks the field bottom-up one row per enabled cycle, dropping full rows.
module field_row_compact
    import field_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_i,
    input  logic                           en_i,
    input  logic [FIELD_W*FIELD_H-1:0]     field_i,
    output logic [FIELD_W*FIELD_H-1:0]     field_d_o,
    output logic [$clog2(FIELD_H+1)-1:0]   count_d_o,
    output logic                           last_o
);

    localparam int FA = FIELD_W * FIELD_H;
    localparam int RW = $clog2(FIELD_H);
    localparam int CW = $clog2(FIELD_H + 1);

    logic [RW-1:0]      rd_q, rd_d;
    logic [RW-1:0]      wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FA-1:0]      out_q, out_d;
    logic [FIELD_W-1:0] row;
    logic               row_full;

    // Each surviving row is written exactly once into a zeroed buffer, so OR-ing it in is enough.
    always_comb begin
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        row      = FIELD_W'(field_i >> (int'(rd_q) * FIELD_W));
        row_full = &row;
        if (init_i) begin
            rd_d  = RW'(FIELD_H - 1);
            wr_d  = RW'(FIELD_H - 1);
            cnt_d = '0;
            out_d = '0;
        end else if (en_i) begin
            rd_d = rd_q - RW'(1);
            if (row_full) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                out_d = out_q | (FA'(row) << (int'(wr_q) * FIELD_W));
                wr_d  = wr_q - RW'(1);
            end
        end
    end

    assign field_d_o = out_d;
    assign count_d_o = cnt_d;
    assign last_o    = en_i && (rd_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/field_lock_engine.sv
// Sequential piece overlay: scans a rotated BLKxBLK piece onto the field one cell per cycle.
// Define FIELD_LOCK_ROWCLR_EN to add the CLEAR pass that compacts full rows after a clean lock.
module field_lock_engine
    import field_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF,
    parameter int BLK     = BLK_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           mode,
    input  logic [1:0]                     rotate,
    input  logic [$clog2(FIELD_W)-1:0]     block_pos_x,
    input  logic [$clog2(FIELD_H)-1:0]     block_pos_y,
    input  logic [BLK*BLK-1:0]             block_matrix,
    input  logic [FIELD_W*FIELD_H-1:0]     field_background,
    output logic                           busy,
    output logic                           done,
    output logic                           collide,
    output logic                           out_of_bounds,
    output logic [FIELD_W*FIELD_H-1:0]     field_out,
    output logic [$clog2(FIELD_H+1)-1:0]   rows_cleared
);

    localparam int FA  = FIELD_W * FIELD_H;
    localparam int XW  = $clog2(FIELD_W);
    localparam int YW  = $clog2(FIELD_H);
    localparam int MW  = $clog2(BLK * BLK);
    localparam int FIW = $clog2(FA);
    localparam int CW  = $clog2(FIELD_H + 1);

    state_e            state_q, state_d;
    logic [MW-1:0]     n_q, n_d;
    logic              mode_q, mode_d;
    logic [1:0]        rot_q, rot_d;
    logic [XW-1:0]     px_q, px_d;
    logic [YW-1:0]     py_q, py_d;
    logic [BLK*BLK-1:0] mat_q, mat_d;
    logic [FA-1:0]     bg_q, bg_d;
    logic [FA-1:0]     work_q, work_d;
    logic              coll_w_q, coll_w_d;
    logic              oob_w_q, oob_w_d;
    logic [FA-1:0]     fout_q, fout_d;
    logic              coll_q, coll_d;
    logic              oob_q, oob_d;

    int                cell_i, cell_j;
    logic              src_bit, in_range;
    logic [XW:0]       tx;
    logic [YW:0]       ty;
    logic [FIW-1:0]    fidx;

`ifdef FIELD_LOCK_ROWCLR_EN
    logic [CW-1:0]     rows_q, rows_d;
    logic [FA-1:0]     comp_field;
    logic [CW-1:0]     comp_count;
    logic              comp_last;

    field_row_compact #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_compact (
        .clk       (clk),
        .rst       (rst),
        .init_i    (state_q == IDLE && start),
        .en_i      (state_q == CLEAR),
        .field_i   (work_q),
        .field_d_o (comp_field),
        .count_d_o (comp_count),
        .last_o    (comp_last)
    );

    assign rows_cleared = rows_q;
`else
    assign rows_cleared = '0;
`endif

    // Target coordinates carry one extra bit so a piece hanging off the right or bottom edge never wraps.
    always_comb begin
        cell_i   = int'(n_q) / BLK;
        cell_j   = int'(n_q) % BLK;
        src_bit  = mat_q[MW'(rot_src_idx(rot_q, cell_i, cell_j, BLK))];
        tx       = {1'b0, px_q} + (XW+1)'(cell_j);
        ty       = {1'b0, py_q} + (YW+1)'(cell_i);
        in_range = (tx < (XW+1)'(FIELD_W)) && (ty < (YW+1)'(FIELD_H));
        fidx     = FIW'(int'(ty) * FIELD_W + int'(tx));
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        mode_d   = mode_q;
        rot_d    = rot_q;
        px_d     = px_q;
        py_d     = py_q;
        mat_d    = mat_q;
        bg_d     = bg_q;
        work_d   = work_q;
        coll_w_d = coll_w_q;
        oob_w_d  = oob_w_q;
        fout_d   = fout_q;
        coll_d   = coll_q;
        oob_d    = oob_q;
`ifdef FIELD_LOCK_ROWCLR_EN
        rows_d   = rows_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    n_d      = '0;
                    mode_d   = mode;
                    rot_d    = rotate;
                    px_d     = block_pos_x;
                    py_d     = block_pos_y;
                    mat_d    = block_matrix;
                    bg_d     = field_background;
                    work_d   = field_background;
                    coll_w_d = 1'b0;
                    oob_w_d  = 1'b0;
                end
            end
            SCAN: begin
                if (src_bit) begin
                    if (!in_range) begin
                        oob_w_d = 1'b1;
                    end else if (bg_q[fidx]) begin
                        coll_w_d = 1'b1;
                    end else begin
                        work_d[fidx] = 1'b1;
                    end
                end
                n_d = n_q + MW'(1);
                if (n_q == MW'(BLK * BLK - 1)) begin
                    state_d = DONE;
`ifdef FIELD_LOCK_ROWCLR_EN
                    if (mode_q && !coll_w_d && !oob_w_d) begin
                        state_d = CLEAR;
                    end
`endif
                    // A rejected lock hands back the untouched snapshot.
                    if (state_d == DONE) begin
                        fout_d = (mode_q && (coll_w_d || oob_w_d)) ? bg_q : work_d;
                        coll_d = coll_w_d;
                        oob_d  = oob_w_d;
`ifdef FIELD_LOCK_ROWCLR_EN
                        rows_d = '0;
`endif
                    end
                end
            end
`ifdef FIELD_LOCK_ROWCLR_EN
            CLEAR: begin
                if (comp_last) begin
                    state_d = DONE;
                    fout_d  = comp_field;
                    rows_d  = comp_count;
                    coll_d  = 1'b0;
                    oob_d   = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            mode_q   <= 1'b0;
            rot_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            mat_q    <= '0;
            bg_q     <= '0;
            work_q   <= '0;
            coll_w_q <= 1'b0;
            oob_w_q  <= 1'b0;
            fout_q   <= '0;
            coll_q   <= 1'b0;
            oob_q    <= 1'b0;
`ifdef FIELD_LOCK_ROWCLR_EN
            rows_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            mode_q   <= mode_d;
            rot_q    <= rot_d;
            px_q     <= px_d;
            py_q     <= py_d;
            mat_q    <= mat_d;
            bg_q     <= bg_d;
            work_q   <= work_d;
            coll_w_q <= coll_w_d;
            oob_w_q  <= oob_w_d;
            fout_q   <= fout_d;
            coll_q   <= coll_d;
            oob_q    <= oob_d;
`ifdef FIELD_LOCK_ROWCLR_EN
            rows_q   <= rows_d;
`endif
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign field_out     = fout_q;
    assign collide       = coll_q;
    assign out_of_bounds = oob_q;

endmodule

// File: tb/tb_field_lock_engine.sv
// Bench for field_lock_engine: hand-written vector table, model-checked random vectors and a reset abort.
// Expectations for row compaction follow FIELD_LOCK_ROWCLR_EN when it is defined for the build.
module tb_field_lock_engine;

    localparam int W   = 20;
    localparam int H   = 20;
    localparam int BLK = 4;
    localparam int FA  = W * H;
    localparam int LAT_PLAIN = BLK * BLK + 1;
`ifdef FIELD_LOCK_ROWCLR_EN
    localparam int LAT_CLEAR = BLK * BLK + H + 1;
    localparam bit ROWCLR    = 1'b1;
`else
    localparam int LAT_CLEAR = LAT_PLAIN;
    localparam bit ROWCLR    = 1'b0;
`endif

    typedef struct {
        string          name;
        logic           mode;
        logic [1:0]     rot;
        logic [4:0]     px;
        logic [4:0]     py;
        logic [15:0]    mat;
        logic [FA-1:0]  bg;
        logic [FA-1:0]  expField;
        logic           expColl;
        logic           expOob;
        logic [4:0]     expRows;
        int             expLat;
    } vector_t;

    typedef struct {
        string          name;
        logic [FA-1:0]  field;
        logic           coll;
        logic           oob;
        logic [4:0]     rows;
        int             lat;
    } expect_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           mode;
    logic [1:0]     rotate;
    logic [4:0]     posX;
    logic [4:0]     posY;
    logic [15:0]    matrix;
    logic [FA-1:0]  background;
    logic           busy;
    logic           done;
    logic           collide;
    logic           outOfBounds;
    logic [FA-1:0]  fieldOut;
    logic [4:0]     rowsCleared;

    int             checks = 0;
    int             errors = 0;
    expect_t        sbQueue[$];
    vector_t        vecs[10];

    field_lock_engine dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .rotate           (rotate),
        .block_pos_x      (posX),
        .block_pos_y      (posY),
        .block_matrix     (matrix),
        .field_background (background),
        .busy             (busy),
        .done             (done),
        .collide          (collide),
        .out_of_bounds    (outOfBounds),
        .field_out        (fieldOut),
        .rows_cleared     (rowsCleared)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [FA-1:0] withCell(logic [FA-1:0] f, int x, int y);
        f[y * W + x] = 1'b1;
        return f;
    endfunction

    function automatic vector_t mkVec(string name, logic md, logic [1:0] rot, logic [4:0] px, logic [4:0] py,
                                      logic [15:0] mat, logic [FA-1:0] bg, logic [FA-1:0] ef,
                                      logic ec, logic eo, logic [4:0] er, int el);
        vector_t v;
        v.name = name; v.mode = md; v.rot = rot; v.px = px; v.py = py; v.mat = mat; v.bg = bg;
        v.expField = ef; v.expColl = ec; v.expOob = eo; v.expRows = er; v.expLat = el;
        return v;
    endfunction

    // Reference: rotate the piece as a 2-D array k times, place it, then compact if the lock is clean.
    function automatic expect_t modelResult(vector_t v);
        expect_t       e;
        bit            m[BLK][BLK];
        bit            t[BLK][BLK];
        logic [FA-1:0] work;
        logic [FA-1:0] compacted;
        logic [W-1:0]  row;
        int            x, y, wr;
        work = v.bg;
        for (int a = 0; a < BLK; a++)
            for (int b = 0; b < BLK; b++)
                m[a][b] = v.mat[a * BLK + b];
        for (int k = 0; k < int'(v.rot); k++) begin
            for (int a = 0; a < BLK; a++)
                for (int b = 0; b < BLK; b++)
                    t[a][b] = m[BLK - 1 - b][a];
            m = t;
        end
        e.name = v.name; e.coll = 1'b0; e.oob = 1'b0; e.rows = '0; e.lat = LAT_PLAIN;
        for (int a = 0; a < BLK; a++) begin
            for (int b = 0; b < BLK; b++) begin
                if (m[a][b]) begin
                    x = int'(v.px) + b;
                    y = int'(v.py) + a;
                    if (x >= W || y >= H) e.oob = 1'b1;
                    else if (v.bg[y * W + x]) e.coll = 1'b1;
                    else work[y * W + x] = 1'b1;
                end
            end
        end
        if (!v.mode) begin
            e.field = work;
        end else if (e.coll || e.oob) begin
            e.field = v.bg;
        end else if (ROWCLR) begin
            compacted = '0;
            wr = H - 1;
            for (int rd = H - 1; rd >= 0; rd--) begin
                for (int c = 0; c < W; c++) row[c] = work[rd * W + c];
                if (&row) begin
                    e.rows = e.rows + 5'd1;
                end else begin
                    for (int c = 0; c < W; c++) compacted[wr * W + c] = row[c];
                    wr--;
                end
            end
            e.field = compacted;
            e.lat = LAT_CLEAR;
        end else begin
            e.field = work;
        end
        return e;
    endfunction

    function automatic expect_t fromTable(vector_t v);
        expect_t e;
        e.name = v.name; e.field = v.expField; e.coll = v.expColl; e.oob = v.expOob;
        e.rows = v.expRows; e.lat = v.expLat;
        return e;
    endfunction

    task automatic checkOutput(string name, logic [FA-1:0] actual, logic [FA-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic scrambleInputs();
        mode       = 1'($urandom);
        rotate     = 2'($urandom);
        posX       = 5'($urandom);
        posY       = 5'($urandom);
        matrix     = 16'($urandom);
        background = ~background;
        start      = 1'($urandom);
    endtask

    // Drives one request, pushes its expectation, then waits (bounded) for done and scores it.
    task automatic applyStimulus(vector_t v, expect_t e);
        expect_t got;
        int      cycles;
        @(negedge clk);
        mode = v.mode; rotate = v.rot; posX = v.px; posY = v.py; matrix = v.mat; background = v.bg;
        start = 1'b1;
        sbQueue.push_back(e);
        @(negedge clk);
        cycles = 1;
        checkOutput({v.name, "/busy"}, FA'(busy), FA'(1));
        while (!done && cycles < 80) begin
            scrambleInputs();
            @(negedge clk);
            cycles++;
        end
        got = sbQueue.pop_front();
        checkOutput({got.name, "/latency"}, FA'(cycles), FA'(got.lat));
        checkOutput({got.name, "/field"}, fieldOut, got.field);
        checkOutput({got.name, "/collide"}, FA'(collide), FA'(got.coll));
        checkOutput({got.name, "/oob"}, FA'(outOfBounds), FA'(got.oob));
        checkOutput({got.name, "/rows"}, FA'(rowsCleared), FA'(got.rows));
        start = 1'b1;
        @(negedge clk);
        checkOutput({got.name, "/idleAfterDone"}, FA'(busy), FA'(0));
        start = 1'b0;
    endtask

    task automatic runResetAbort(vector_t v);
        bit sawDone;
        @(negedge clk);
        mode = v.mode; rotate = v.rot; posX = v.px; posY = v.py; matrix = v.mat; background = v.bg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sawDone = done;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort/noDone", FA'(sawDone), FA'(0));
        checkOutput("abort/busy", FA'(busy), FA'(0));
        checkOutput("abort/field", fieldOut, '0);
        checkOutput("abort/collide", FA'(collide), FA'(0));
        checkOutput("abort/oob", FA'(outOfBounds), FA'(0));
        checkOutput("abort/rows", FA'(rowsCleared), FA'(0));
    endtask

    initial begin
        logic [FA-1:0] bg;
        logic [FA-1:0] ef;
        logic [FA-1:0] row19;
        vector_t       rv;

        ef = '0;
        ef = withCell(ef, 6, 5); ef = withCell(ef, 7, 5); ef = withCell(ef, 6, 6); ef = withCell(ef, 7, 6);
        vecs[0] = mkVec("opiece", 1'b0, 2'd0, 5'd5, 5'd5, 16'h0066, '0, ef, 1'b0, 1'b0, 5'd0, LAT_PLAIN);

        ef = '0;
        for (int y = 0; y < 4; y++) ef = withCell(ef, 2, y);
        vecs[1] = mkVec("iRot1", 1'b0, 2'd1, 5'd0, 5'd0, 16'h00F0, '0, ef, 1'b0, 1'b0, 5'd0, LAT_PLAIN);

        bg = withCell('0, 6, 6);
        vecs[2] = mkVec("lockCollide", 1'b1, 2'd0, 5'd5, 5'd5, 16'h0066, bg, bg, 1'b1, 1'b0, 5'd0, LAT_PLAIN);

        vecs[3] = mkVec("lockOob", 1'b1, 2'd0, 5'd18, 5'd0, 16'h00F0, '0, '0, 1'b0, 1'b1, 5'd0, LAT_PLAIN);

        row19 = '0;
        for (int x = 4; x < W; x++) row19 = withCell(row19, x, 19);
        bg = withCell(row19, 7, 18);
        if (ROWCLR) ef = withCell('0, 7, 19);
        else ef = bg | withCell(withCell(withCell(withCell('0, 0, 19), 1, 19), 2, 19), 3, 19);
        vecs[4] = mkVec("rowClear", 1'b1, 2'd0, 5'd0, 5'd19, 16'h000F, bg, ef, 1'b0, 1'b0,
                        ROWCLR ? 5'd1 : 5'd0, LAT_CLEAR);

        bg = withCell('0, 13, 13);
        vecs[5] = mkVec("rot2Collide", 1'b0, 2'd2, 5'd10, 5'd10, 16'h0001, bg, bg, 1'b1, 1'b0, 5'd0, LAT_PLAIN);

        vecs[6] = mkVec("rot3", 1'b0, 2'd3, 5'd10, 5'd10, 16'h0001, '0, withCell('0, 10, 13),
                        1'b0, 1'b0, 5'd0, LAT_PLAIN);

        bg = withCell('0, 0, 0);
        vecs[7] = mkVec("wideOob", 1'b0, 2'd0, 5'd29, 5'd0, 16'h000F, bg, bg, 1'b0, 1'b1, 5'd0, LAT_PLAIN);

        bg = '0;
        for (int x = 0; x < W; x++) begin
            bg = withCell(bg, x, 19);
            bg = withCell(bg, x, 17);
        end
        bg = withCell(withCell(bg, 3, 18), 9, 16);
        if (ROWCLR) ef = withCell(withCell(withCell('0, 3, 19), 9, 18), 0, 2);
        else ef = withCell(bg, 0, 0);
        vecs[8] = mkVec("multiClear", 1'b1, 2'd0, 5'd0, 5'd0, 16'h0001, bg, ef, 1'b0, 1'b0,
                        ROWCLR ? 5'd2 : 5'd0, LAT_CLEAR);

        ef = withCell(withCell(withCell(withCell('0, 0, 18), 1, 18), 0, 19), 1, 19);
        vecs[9] = mkVec("lockClean", 1'b1, 2'd0, 5'd0, 5'd18, 16'h0033, '0, ef, 1'b0, 1'b0, 5'd0, LAT_CLEAR);

        rst = 1'b1; start = 1'b0; mode = 1'b0; rotate = '0; posX = '0; posY = '0; matrix = '0; background = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset/busy", FA'(busy), FA'(0));
        checkOutput("reset/done", FA'(done), FA'(0));
        checkOutput("reset/collide", FA'(collide), FA'(0));
        checkOutput("reset/oob", FA'(outOfBounds), FA'(0));
        checkOutput("reset/field", fieldOut, '0);
        checkOutput("reset/rows", FA'(rowsCleared), FA'(0));
        rst = 1'b0;

        for (int n = 0; n < 10; n++) applyStimulus(vecs[n], fromTable(vecs[n]));

        for (int n = 0; n < 8; n++) begin
            rv.name = $sformatf("rand%0d", n);
            rv.mode = (n % 2 == 1);
            rv.rot  = 2'($urandom);
            rv.px   = 5'($urandom_range(0, 22));
            rv.py   = 5'($urandom_range(0, 22));
            rv.mat  = 16'($urandom & $urandom);
            rv.bg   = '0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    if (y >= 12 && ($urandom_range(0, 3) == 0 || y % 3 == 0)) rv.bg[y * W + x] = 1'b1;
            applyStimulus(rv, modelResult(rv));
        end

        applyStimulus(vecs[0], fromTable(vecs[0]));
        runResetAbort(vecs[0]);
        applyStimulus(vecs[0], fromTable(vecs[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
